// File: rtl/cache_l2_nway_if.sv
// cache_l2_nway_if: bus bundle between the L1 arbiter, the L2 cache and physical memory.
//   mem_*   : L1-side request/response (read, write, byte enables, one-cycle mem_resp)
//   pmem_*  : physical memory line fill / write-back handshake
//   flush_* : whole-cache write-back request and completion pulse
//   *_count : saturating hit/miss statistics
//   modport slave  : the cache's view
//   modport master : the environment's view (L1 arbiter plus physical memory)
interface cache_l2_nway_if #(
    parameter int LINE_BITS = 128,
    parameter int CNT_W     = 16
);
    logic                   mem_read;
    logic                   mem_write;
    logic [15:0]            mem_address;
    logic [LINE_BITS-1:0]   mem_wdata;
    logic [LINE_BITS/8-1:0] mem_byte_enable;
    logic [LINE_BITS-1:0]   mem_rdata;
    logic                   mem_resp;
    logic                   pmem_read;
    logic                   pmem_write;
    logic [15:0]            pmem_address;
    logic [LINE_BITS-1:0]   pmem_wdata;
    logic                   pmem_resp;
    logic [LINE_BITS-1:0]   pmem_rdata;
    logic                   flush_req;
    logic                   flush_done;
    logic [CNT_W-1:0]       hit_count;
    logic [CNT_W-1:0]       miss_count;
    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  pmem_resp, pmem_rdata, flush_req,
        output mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
        output flush_done, hit_count, miss_count
    );
    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output pmem_resp, pmem_rdata, flush_req,
        input  mem_rdata, mem_resp, pmem_read, pmem_write, pmem_address, pmem_wdata,
        input  flush_done, hit_count, miss_count
    );
endinterface

// File: rtl/cache_l2_nway.sv
// cache_l2_nway: N-way set-associative write-back, write-allocate L2 cache with tree PLRU,
// per-byte writes, whole-cache flush and saturating hit/miss counters.
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-low
//   bus   : cache_l2_nway_if.slave (mem_* request side, pmem_* memory side, flush, counters)
module cache_l2_nway #(
    parameter int WAYS      = 4,
    parameter int SETS      = 8,
    parameter int LOG_SETS  = 3,
    parameter int LINE_BITS = 128,
    parameter int LOG_OFF   = 4,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    cache_l2_nway_if.slave       bus
);
    localparam int LOG_WAYS = $clog2(WAYS);
    localparam int TAG_W    = 16 - LOG_OFF - LOG_SETS;
    localparam int BYTES    = LINE_BITS / 8;
    localparam int PTR_W    = LOG_SETS + LOG_WAYS;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WB    = 3'd1;
    localparam logic [2:0] S_ALLOC = 3'd2;
    localparam logic [2:0] S_FSCAN = 3'd3;
    localparam logic [2:0] S_FWB   = 3'd4;

    logic [LINE_BITS-1:0] r_data  [SETS][WAYS];
    logic [TAG_W-1:0]     r_tag   [SETS][WAYS];
    logic [WAYS-1:0]      r_valid [SETS];
    logic [WAYS-1:0]      r_dirty [SETS];
    logic [WAYS-2:0]      r_plru  [SETS];
    logic [2:0]           r_state;
    logic [LOG_WAYS-1:0]  r_victim;
    logic [PTR_W-1:0]     r_fptr;
    logic                 r_retry;
    logic                 r_flush_arm;
    logic                 r_flush_done;
    logic [CNT_W-1:0]     r_hits;
    logic [CNT_W-1:0]     r_misses;

    logic [LOG_SETS-1:0]  w_index;
    logic [TAG_W-1:0]     w_tag;
    logic                 w_req;
    logic                 w_idle;
    logic                 w_flushing;
    logic [LOG_SETS-1:0]  w_fset;
    logic [LOG_WAYS-1:0]  w_fway;
    logic [LOG_SETS-1:0]  w_set;
    logic [LOG_WAYS-1:0]  w_way;
    logic                 w_hit;
    logic [LOG_WAYS-1:0]  w_hit_way;
    logic                 w_inv;
    logic [LOG_WAYS-1:0]  w_inv_way;
    logic [LOG_WAYS-1:0]  w_vict;
    logic [LINE_BITS-1:0] w_hit_line;
    logic [LINE_BITS-1:0] w_merged;
    logic                 w_pread;
    logic                 w_pwrite;
    logic                 w_flush_go;
    logic                 w_last;

    // Heap-ordered tree: node n has children 2n and 2n+1, stored at bit n-1.
    // Touching a way makes every node on its path point at the other subtree.
    function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p, input logic [LOG_WAYS-1:0] w);
        int n = 1;
        for (int l = LOG_WAYS - 1; l >= 0; l--) begin
            p[n-1] = ~w[l];
            n = w[l] ? 2 * n + 1 : 2 * n;
        end
        return p;
    endfunction

    function automatic logic [LOG_WAYS-1:0] plru_victim(input logic [WAYS-2:0] p);
        logic [LOG_WAYS-1:0] v = '0;
        int n = 1;
        for (int l = LOG_WAYS - 1; l >= 0; l--) begin
            v[l] = p[n-1];
            n = p[n-1] ? 2 * n + 1 : 2 * n;
        end
        return v;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    assign w_index    = bus.mem_address[LOG_OFF+LOG_SETS-1:LOG_OFF];
    assign w_tag      = bus.mem_address[15:LOG_OFF+LOG_SETS];
    assign w_req      = bus.mem_read | bus.mem_write;
    assign w_idle     = r_state == S_IDLE;
    assign w_flushing = r_state == S_FSCAN || r_state == S_FWB;
    assign w_fset     = r_fptr[PTR_W-1:LOG_WAYS];
    assign w_fway     = r_fptr[LOG_WAYS-1:0];
    assign w_last     = &r_fptr;
    // Write-back source: the scan entry while flushing, else the latched victim.
    assign w_set      = w_flushing ? w_fset : w_index;
    assign w_way      = w_flushing ? w_fway : r_victim;
    assign w_flush_go = w_idle && !w_req && bus.flush_req && r_flush_arm;

    always_comb begin
        w_hit     = 1'b0;
        w_hit_way = '0;
        for (int w = 0; w < WAYS; w++)
            if (r_valid[w_index][w] && r_tag[w_index][w] == w_tag) begin
                w_hit     = 1'b1;
                w_hit_way = LOG_WAYS'(w);
            end
    end

    // Descending scan so the lowest-index invalid way wins.
    always_comb begin
        w_inv     = 1'b0;
        w_inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--)
            if (!r_valid[w_index][w]) begin
                w_inv     = 1'b1;
                w_inv_way = LOG_WAYS'(w);
            end
    end

    assign w_vict     = w_inv ? w_inv_way : plru_victim(r_plru[w_index]);
    assign w_hit_line = r_data[w_index][w_hit_way];

    always_comb begin
        w_merged = w_hit_line;
        for (int b = 0; b < BYTES; b++)
            w_merged[8*b +: 8] = bus.mem_byte_enable[b] ? bus.mem_wdata[8*b +: 8] : w_hit_line[8*b +: 8];
    end

    assign w_pread          = r_state == S_ALLOC;
    assign w_pwrite         = r_state == S_WB || r_state == S_FWB;
    assign bus.mem_resp     = w_idle && w_req && w_hit;
    assign bus.mem_rdata    = w_hit_line;
    assign bus.pmem_read    = w_pread;
    assign bus.pmem_write   = w_pwrite;
    assign bus.pmem_address = w_pwrite ? {r_tag[w_set][w_way], w_set, {LOG_OFF{1'b0}}} :
                              w_pread  ? {w_tag, w_index, {LOG_OFF{1'b0}}} : 16'd0;
    assign bus.pmem_wdata   = r_data[w_set][w_way];
    assign bus.flush_done   = r_flush_done;
    assign bus.hit_count    = r_hits;
    assign bus.miss_count   = r_misses;

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_dirty[s] <= '0;
                r_plru[s]  <= '0;
            end
            r_state      <= S_IDLE;
            r_victim     <= '0;
            r_fptr       <= '0;
            r_retry      <= 1'b0;
            r_flush_arm  <= 1'b1;
            r_flush_done <= 1'b0;
            r_hits       <= '0;
            r_misses     <= '0;
        end else begin
            r_flush_done <= 1'b0;
            if (!bus.flush_req)
                r_flush_arm <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    r_retry <= 1'b0;
                    if (w_req && w_hit) begin
                        r_plru[w_index] <= plru_touch(r_plru[w_index], w_hit_way);
                        // The hit that completes a fill was already counted as a miss.
                        if (!r_retry)
                            r_hits <= sat_inc(r_hits);
                        if (bus.mem_write) begin
                            r_data[w_index][w_hit_way]  <= w_merged;
                            r_dirty[w_index][w_hit_way] <= 1'b1;
                        end
                    end else if (w_req) begin
                        r_misses <= sat_inc(r_misses);
                        r_victim <= w_vict;
                        r_state  <= (r_valid[w_index][w_vict] && r_dirty[w_index][w_vict]) ? S_WB : S_ALLOC;
                    end else if (w_flush_go) begin
                        r_flush_arm <= 1'b0;
                        r_fptr      <= '0;
                        r_state     <= S_FSCAN;
                    end
                end
                S_WB:
                    if (bus.pmem_resp)
                        r_state <= S_ALLOC;
                S_ALLOC:
                    if (bus.pmem_resp) begin
                        r_data[w_index][r_victim]  <= bus.pmem_rdata;
                        r_tag[w_index][r_victim]   <= w_tag;
                        r_valid[w_index][r_victim] <= 1'b1;
                        r_dirty[w_index][r_victim] <= 1'b0;
                        r_plru[w_index]            <= plru_touch(r_plru[w_index], r_victim);
                        r_retry                    <= 1'b1;
                        r_state                    <= S_IDLE;
                    end
                S_FSCAN:
                    if (r_valid[w_fset][w_fway] && r_dirty[w_fset][w_fway])
                        r_state <= S_FWB;
                    else if (w_last) begin
                        r_flush_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end else
                        r_fptr <= r_fptr + 1'b1;
                S_FWB:
                    if (bus.pmem_resp) begin
                        r_dirty[w_fset][w_fway] <= 1'b0;
                        if (w_last) begin
                            r_flush_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_fptr  <= r_fptr + 1'b1;
                            r_state <= S_FSCAN;
                        end
                    end
                default:
                    r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_l2_nway.sv
// tb_cache_l2_nway: directed self-checking bench for cache_l2_nway with a fixed-latency pmem model.
module tb_cache_l2_nway;
    localparam int LAT = 2;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    cache_l2_nway_if #(.LINE_BITS(128), .CNT_W(16)) bus ();

    cache_l2_nway dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            checks = 0;
    int            fails  = 0;
    int            cyc;
    bit            both_seen = 0;
    logic [127:0]  rdata;
    logic [15:0]   wb_addr [$];
    logic [127:0]  wb_data [$];
    logic [15:0]   rd_addr [$];

    localparam logic [127:0] M = 128'hA5A5A5A5_A5A5A5A5_11111111_A5A5A5A5;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One cycle of the memory model; called at negedge+1, responds after LAT cycles of a request.
    task automatic pmem_cycle(inout int cnt);
        if (bus.pmem_read && bus.pmem_write) both_seen = 1;
        if (bus.pmem_read || bus.pmem_write) begin
            cnt++;
            if (cnt >= LAT) begin
                cnt = 0;
                bus.pmem_resp = 1'b1;
                if (bus.pmem_write) begin
                    wb_addr.push_back(bus.pmem_address);
                    wb_data.push_back(bus.pmem_wdata);
                end else
                    rd_addr.push_back(bus.pmem_address);
            end
        end
    endtask

    task automatic access(input logic wr, input logic [15:0] a, input logic [127:0] wd, input logic [15:0] be);
        int cnt = 0;
        bit done = 0;
        wb_addr.delete(); wb_data.delete(); rd_addr.delete();
        bus.mem_read = !wr; bus.mem_write = wr; bus.mem_address = a;
        bus.mem_wdata = wd; bus.mem_byte_enable = be;
        cyc = 0;
        while (!done && cyc < 100) begin
            #1;
            if (bus.mem_resp) begin
                done  = 1;
                rdata = bus.mem_rdata;
            end else
                pmem_cycle(cnt);
            @(posedge clk);
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (!done) cyc++;
        end
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        chk("mem_resp_seen", done, 1);
    endtask

    task automatic flush();
        int cnt = 0;
        bit done = 0;
        wb_addr.delete(); wb_data.delete(); rd_addr.delete();
        bus.flush_req = 1'b1;
        cyc = 0;
        while (!done && cyc < 200) begin
            #1;
            if (bus.flush_done) done = 1;
            else pmem_cycle(cnt);
            @(posedge clk);
            @(negedge clk);
            bus.pmem_resp = 1'b0;
            if (!done) cyc++;
        end
        bus.flush_req = 1'b0;
        chk("flush_done_seen", done, 1);
        #1;
        chk("flush_done_single", bus.flush_done, 0);
        @(negedge clk);
    endtask

    initial begin
        bus.mem_read = 0; bus.mem_write = 0; bus.mem_address = 0; bus.mem_wdata = 0;
        bus.mem_byte_enable = 0; bus.pmem_resp = 0; bus.pmem_rdata = 0; bus.flush_req = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_mem_resp", bus.mem_resp, 0);
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_write", bus.pmem_write, 0);
        chk("rst_flush_done", bus.flush_done, 0);
        chk("rst_pmem_address", bus.pmem_address, 0);
        chk("rst_hit_count", bus.hit_count, 0);
        chk("rst_miss_count", bus.miss_count, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // A stray pmem_resp in IDLE must not start anything.
        bus.pmem_resp = 1'b1;
        @(negedge clk);
        bus.pmem_resp = 1'b0;
        #1;
        chk("late_resp_pmem_read", bus.pmem_read, 0);
        chk("late_resp_pmem_write", bus.pmem_write, 0);
        @(negedge clk);

        // 1: clean miss
        bus.pmem_rdata = {16{8'hA5}};
        access(0, 16'h0000, '0, '0);
        chk("t1_latency", cyc, 3);
        chk("t1_nfill", rd_addr.size(), 1);
        chk("t1_fill_addr", rd_addr[0], 16'h0000);
        chk("t1_nwb", wb_addr.size(), 0);
        chk("t1_rdata", rdata, {16{8'hA5}});
        chk("t1_miss", bus.miss_count, 1);
        chk("t1_hit", bus.hit_count, 0);

        // 2: read hit
        access(0, 16'h0000, '0, '0);
        chk("t2_latency", cyc, 0);
        chk("t2_nfill", rd_addr.size(), 0);
        chk("t2_rdata", rdata, {16{8'hA5}});
        chk("t2_hit", bus.hit_count, 1);

        // 3: byte-enabled write hit then readback
        access(1, 16'h0004, {16{8'h11}}, 16'h00F0);
        chk("t3_wr_latency", cyc, 0);
        chk("t3_wr_hit", bus.hit_count, 2);
        access(0, 16'h0000, '0, '0);
        chk("t3_rdata", rdata, M);
        chk("t3_hit", bus.hit_count, 3);

        // 4: fill set 0, hit way 0, PLRU picks way 2 (clean, no write-back)
        bus.pmem_rdata = {16{8'hB1}};
        access(0, 16'h0080, '0, '0);
        chk("t4_fill1_latency", cyc, 3);
        bus.pmem_rdata = {16{8'hB2}};
        access(0, 16'h0100, '0, '0);
        chk("t4_fill2_rdata", rdata, {16{8'hB2}});
        bus.pmem_rdata = {16{8'hB3}};
        access(0, 16'h0180, '0, '0);
        chk("t4_fill3_nwb", wb_addr.size(), 0);
        access(0, 16'h0000, '0, '0);
        chk("t4_hit0_rdata", rdata, M);
        bus.pmem_rdata = {16{8'hC0}};
        access(0, 16'h0200, '0, '0);
        chk("t4_latency", cyc, 3);
        chk("t4_nwb", wb_addr.size(), 0);
        chk("t4_nfill", rd_addr.size(), 1);
        chk("t4_fill_addr", rd_addr[0], 16'h0200);
        chk("t4_rdata", rdata, {16{8'hC0}});
        chk("t4_miss", bus.miss_count, 5);
        chk("t4_hit", bus.hit_count, 4);

        // 5: dirty 0x0080 and steer PLRU onto way 1, then evict it
        access(1, 16'h0080, {16{8'h22}}, 16'hFFFF);
        access(0, 16'h0000, '0, '0);
        access(0, 16'h0200, '0, '0);
        chk("t5_hits", bus.hit_count, 7);
        bus.pmem_rdata = {16{8'hD0}};
        access(0, 16'h0280, '0, '0);
        chk("t5_latency", cyc, 5);
        chk("t5_nwb", wb_addr.size(), 1);
        chk("t5_wb_addr", wb_addr[0], 16'h0080);
        chk("t5_wb_data", wb_data[0], {16{8'h22}});
        chk("t5_nfill", rd_addr.size(), 1);
        chk("t5_fill_addr", rd_addr[0], 16'h0280);
        chk("t5_rdata", rdata, {16{8'hD0}});
        chk("t5_miss", bus.miss_count, 6);

        // 6: two dirty lines (0x0000, 0x0200) flushed, then a clean re-flush
        access(1, 16'h0200, {16{8'h33}}, 16'hFFFF);
        chk("t6_wr_hit", bus.hit_count, 8);
        flush();
        chk("t6_flush_cycles", cyc, 37);
        chk("t6_nwb", wb_addr.size(), 2);
        chk("t6_wb0_addr", wb_addr[0], 16'h0000);
        chk("t6_wb0_data", wb_data[0], M);
        chk("t6_wb1_addr", wb_addr[1], 16'h0200);
        chk("t6_wb1_data", wb_data[1], {16{8'h33}});
        flush();
        chk("t6_clean_flush_cycles", cyc, 33);
        chk("t6_clean_nwb", wb_addr.size(), 0);
        access(0, 16'h0000, '0, '0);
        chk("t6_post_flush_latency", cyc, 0);
        chk("t6_post_flush_rdata", rdata, M);
        chk("t6_post_flush_hit", bus.hit_count, 9);
        chk("t6_post_flush_miss", bus.miss_count, 6);
        chk("pmem_rw_exclusive", both_seen, 0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
